dmem2_responder: RTL and testbench

//   Dual-port data-memory responder: the memory side of the 2-wide processor's dmem interface.

---
 rtl/dmem2_responder_if.sv | 27 ++
 rtl/dmem2_responder.sv | 148 ++++++++++++++
 tb/tb_dmem2_responder.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/dmem2_responder_if.sv
// Processor-to-memory bus of the 2-wide dmem responder.
// Slot a is the older instruction and slot b is the younger one.
interface dmem2_responder_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] address_a;
  logic [ADDR_W-1:0] address_b;
  logic [DATA_W-1:0] data_a;
  logic [DATA_W-1:0] data_b;
  logic              wren_a;
  logic              wren_b;
  logic [DATA_W-1:0] q_a;
  logic [DATA_W-1:0] q_b;
  logic              ready;
  logic              wr_collision;

  modport master (
    output address_a, address_b, data_a, data_b, wren_a, wren_b,
    input  q_a, q_b, ready, wr_collision
  );

  modport slave (
    input  address_a, address_b, data_a, data_b, wren_a, wren_b,
    output q_a, q_b, ready, wr_collision
  );
endinterface

// File: rtl/dmem2_responder.sv
// Dual-port data memory with write-first reads, a younger-slot-wins write
// collision policy, and a zero-fill sweep after reset.
module dmem2_responder #(
  parameter int ADDR_W         = 12,
  parameter int DATA_W         = 32,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input logic               clock,
  input logic               reset,
  dmem2_responder_if.slave  bus
);
  localparam int                DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_PAIR = ADDR_W'(DEPTH - 2);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam state_t RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

  logic [DATA_W-1:0] mem_r [DEPTH];
  state_t            state_r;
  state_t            next_state_s;
  logic [ADDR_W-1:0] clr_ptr_r;
  logic [ADDR_W-1:0] next_clr_ptr_s;
  logic [DATA_W-1:0] q_a_r;
  logic [DATA_W-1:0] q_b_r;
  logic [DATA_W-1:0] next_q_a_s;
  logic [DATA_W-1:0] next_q_b_s;
  logic              ready_r;
  logic              wr_collision_r;
  logic              collision_s;
  logic              wr_en_a_s;
  logic              wr_en_b_s;
  logic [ADDR_W-1:0] wr_addr_a_s;
  logic [ADDR_W-1:0] wr_addr_b_s;
  logic [DATA_W-1:0] wr_data_a_s;
  logic [DATA_W-1:0] wr_data_b_s;

  // Value an address holds after this edge's writes; slot b is younger and wins.
  function automatic logic [DATA_W-1:0] fwd_read(
    input logic [ADDR_W-1:0] rd_addr,
    input logic [DATA_W-1:0] stored,
    input logic              wa,
    input logic [ADDR_W-1:0] aa,
    input logic [DATA_W-1:0] da,
    input logic              wb,
    input logic [ADDR_W-1:0] ab,
    input logic [DATA_W-1:0] db
  );
    logic [DATA_W-1:0] val;
    if (wb && (ab == rd_addr)) begin
      val = db;
    end else if (wa && (aa == rd_addr)) begin
      val = da;
    end else begin
      val = stored;
    end
    return val;
  endfunction

  // Next-state, write-port steering and read-data selection.
  always_comb begin
    next_state_s   = state_r;
    next_clr_ptr_s = clr_ptr_r;
    next_q_a_s     = '0;
    next_q_b_s     = '0;
    collision_s    = 1'b0;
    wr_en_a_s      = 1'b0;
    wr_en_b_s      = 1'b0;
    wr_addr_a_s    = bus.address_a;
    wr_addr_b_s    = bus.address_b;
    wr_data_a_s    = bus.data_a;
    wr_data_b_s    = bus.data_b;
    case (state_r)
      ST_CLEAR: begin
        wr_en_a_s      = 1'b1;
        wr_en_b_s      = 1'b1;
        wr_addr_a_s    = clr_ptr_r;
        wr_addr_b_s    = clr_ptr_r + ADDR_W'(1);
        wr_data_a_s    = '0;
        wr_data_b_s    = '0;
        next_clr_ptr_s = clr_ptr_r + ADDR_W'(2);
        if (clr_ptr_r == LAST_PAIR) begin
          next_state_s = ST_RUN;
        end else begin
          next_state_s = ST_CLEAR;
        end
      end
      ST_RUN: begin
        next_state_s = ST_RUN;
        // Accesses count only once ready is visible to the processor.
        if (ready_r) begin
          collision_s = bus.wren_a && bus.wren_b && (bus.address_a == bus.address_b);
          wr_en_a_s   = bus.wren_a && !collision_s;
          wr_en_b_s   = bus.wren_b;
          next_q_a_s  = fwd_read(bus.address_a, mem_r[bus.address_a], bus.wren_a,
                                 bus.address_a, bus.data_a, bus.wren_b,
                                 bus.address_b, bus.data_b);
          next_q_b_s  = fwd_read(bus.address_b, mem_r[bus.address_b], bus.wren_a,
                                 bus.address_a, bus.data_a, bus.wren_b,
                                 bus.address_b, bus.data_b);
        end else begin
          collision_s = 1'b0;
        end
      end
      default: begin
        next_state_s   = RESET_STATE;
        next_clr_ptr_s = '0;
      end
    endcase
  end

  // Control state and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r        <= RESET_STATE;
      clr_ptr_r      <= '0;
      q_a_r          <= '0;
      q_b_r          <= '0;
      ready_r        <= 1'b0;
      wr_collision_r <= 1'b0;
    end else begin
      state_r        <= next_state_s;
      clr_ptr_r      <= next_clr_ptr_s;
      q_a_r          <= next_q_a_s;
      q_b_r          <= next_q_b_s;
      ready_r        <= (next_state_s == ST_RUN);
      wr_collision_r <= collision_s;
    end
  end

  // Storage array; deliberately outside the reset domain.
  always_ff @(posedge clock) begin
    if (wr_en_a_s) begin
      mem_r[wr_addr_a_s] <= wr_data_a_s;
    end
    if (wr_en_b_s) begin
      mem_r[wr_addr_b_s] <= wr_data_b_s;
    end
  end

  assign bus.q_a          = q_a_r;
  assign bus.q_b          = q_b_r;
  assign bus.ready        = ready_r;
  assign bus.wr_collision = wr_collision_r;
endmodule

// File: tb/tb_dmem2_responder.sv
// Directed bench for dmem2_responder with ADDR_W=4: clear sweep, write-first
// forwarding, collisions and mid-run reset.
module tb_dmem2_responder;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;

  typedef struct {
    logic        wa;
    logic [3:0]  aa;
    logic [31:0] da;
    logic        wb;
    logic [3:0]  ab;
    logic [31:0] db;
    logic [31:0] qa;
    logic [31:0] qb;
    logic        coll;
  } vec_t;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  vec_t vecs [11];

  dmem2_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dif ();

  dmem2_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CLEAR_ON_RESET(1'b1)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (dif.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic wa, input logic [3:0] aa, input logic [31:0] da,
                       input logic wb, input logic [3:0] ab, input logic [31:0] db);
    @(negedge clock);
    dif.wren_a    = wa;
    dif.address_a = aa;
    dif.data_a    = da;
    dif.wren_b    = wb;
    dif.address_b = ab;
    dif.data_b    = db;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_q_a"}, dif.q_a, 32'h0);
    check({tag, "_q_b"}, dif.q_b, 32'h0);
    check({tag, "_ready"}, {31'h0, dif.ready}, 32'h0);
    check({tag, "_coll"}, {31'h0, dif.wr_collision}, 32'h0);
  endtask

  // Runs the sweep until ready with a cycle bound; returns edges taken.
  task automatic wait_ready(output int edges);
    edges = 0;
    while (dif.ready !== 1'b1 && edges < 20) begin
      step();
      edges++;
    end
  endtask

  initial begin
    int edges;
    checks = 0;
    errors = 0;
    vecs[0]  = '{1'b1, 4'd5,  32'hDEADBEEF, 1'b0, 4'd0,  32'h0,        32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 4'd5,  32'h0,        1'b0, 4'd5,  32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 4'd3,  32'h11,       1'b1, 4'd3,  32'h22,       32'h22,       32'h22,       1'b1};
    vecs[3]  = '{1'b0, 4'd3,  32'h0,        1'b0, 4'd3,  32'h0,        32'h22,       32'h22,       1'b0};
    vecs[4]  = '{1'b0, 4'd7,  32'h0,        1'b1, 4'd7,  32'h55,       32'h55,       32'h55,       1'b0};
    vecs[5]  = '{1'b0, 4'd7,  32'h0,        1'b0, 4'd1,  32'h0,        32'h55,       32'h0,        1'b0};
    vecs[6]  = '{1'b1, 4'd11, 32'hA1,       1'b0, 4'd11, 32'h0,        32'hA1,       32'hA1,       1'b0};
    vecs[7]  = '{1'b1, 4'd9,  32'h1234,     1'b1, 4'd10, 32'h5678,     32'h1234,     32'h5678,     1'b0};
    vecs[8]  = '{1'b0, 4'd9,  32'h0,        1'b0, 4'd10, 32'h0,        32'h1234,     32'h5678,     1'b0};
    vecs[9]  = '{1'b1, 4'd2,  32'h99,       1'b1, 4'd4,  32'h44,       32'h99,       32'h44,       1'b0};
    vecs[10] = '{1'b0, 4'd2,  32'h0,        1'b0, 4'd3,  32'h0,        32'h99,       32'h22,       1'b0};

    reset         = 1'b0;
    dif.wren_a    = 1'b0;
    dif.wren_b    = 1'b0;
    dif.address_a = 4'd0;
    dif.address_b = 4'd0;
    dif.data_a    = 32'h0;
    dif.data_b    = 32'h0;
    step();
    step();
    check_outputs_zero("reset");

    // Sweep with writes attempted throughout: they must be ignored.
    drive(1'b1, 4'd1, 32'hAA, 1'b1, 4'd1, 32'hBB);
    reset = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("clear_ready_e%0d", k), {31'h0, dif.ready}, (k == 8) ? 32'h1 : 32'h0);
      check($sformatf("clear_q_a_e%0d", k), dif.q_a, 32'h0);
      check($sformatf("clear_coll_e%0d", k), {31'h0, dif.wr_collision}, 32'h0);
    end

    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 4'(i), 32'h0, 1'b0, 4'(15 - i), 32'h0);
      step();
      check($sformatf("zero_q_a_%0d", i), dif.q_a, 32'h0);
      check($sformatf("zero_q_b_%0d", 15 - i), dif.q_b, 32'h0);
    end

    for (int v = 0; v < 11; v++) begin
      drive(vecs[v].wa, vecs[v].aa, vecs[v].da, vecs[v].wb, vecs[v].ab, vecs[v].db);
      step();
      check($sformatf("vec%0d_q_a", v), dif.q_a, vecs[v].qa);
      check($sformatf("vec%0d_q_b", v), dif.q_b, vecs[v].qb);
      check($sformatf("vec%0d_coll", v), {31'h0, dif.wr_collision}, {31'h0, vecs[v].coll});
    end

    // Reset mid-run with a write in flight; outputs drop at once.
    drive(1'b1, 4'd2, 32'h77, 1'b0, 4'd5, 32'h0);
    reset = 1'b0;
    #1;
    check_outputs_zero("midrun_reset");
    step();
    step();
    check_outputs_zero("midrun_hold");
    drive(1'b0, 4'd2, 32'h0, 1'b0, 4'd5, 32'h0);
    reset = 1'b1;
    wait_ready(edges);
    check("resweep_edges", 32'(edges), 32'd8);
    drive(1'b0, 4'd2, 32'h0, 1'b0, 4'd5, 32'h0);
    step();
    check("after_reset_addr2", dif.q_a, 32'h0);
    check("after_reset_addr5", dif.q_b, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
